// File: rtl/ghost_mode_pkg.sv
// Shared types, mode encodings and the scatter/chase phase table for the ghost mode scheduler.
package ghost_mode_pkg;

    localparam logic [1:0] CHASE_MODE      = 2'd0;
    localparam logic [1:0] SCATTER_MODE    = 2'd1;
    localparam logic [1:0] FRIGHTENED_MODE = 2'd2;

    typedef enum logic [1:0] {IDLE, SCHED, FRIGHT} sched_state_e;

    // Phase durations in seconds; zero marks the final, endless chase phase.
    function automatic int unsigned phase_sec(logic [2:0] idx);
        case (idx)
            3'd0, 3'd2: return 7;
            3'd4, 3'd6: return 5;
            3'd7:       return 0;
            default:    return 20;
        endcase
    endfunction

    function automatic logic phase_is_chase(logic [2:0] idx);
        return idx[0];
    endfunction

    function automatic logic [1:0] phase_mode(logic [2:0] idx);
        return phase_is_chase(idx) ? CHASE_MODE : SCATTER_MODE;
    endfunction

    function automatic int cnt_width(int ticks_per_sec, int fright_sec);
        int longest;
        longest = 20 * ticks_per_sec;
        if (fright_sec * ticks_per_sec > longest)
            longest = fright_sec * ticks_per_sec;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/ghost_mode_scheduler_if.sv
// Signal bundle between the game core and the ghost mode scheduler.
// The debug override pins exist only when GHOST_MODE_OVERRIDE_EN is defined.
interface ghost_mode_scheduler_if;
    logic       frame_tick;
    logic       level_start;
    logic       pellet_eaten;
    logic       pause;
    logic [1:0] game_mode;
    logic       mode_changed;
    logic       fright_flash;
    logic [2:0] phase_idx;
`ifdef GHOST_MODE_OVERRIDE_EN
    logic       dbg_force_en;
    logic [1:0] dbg_force_mode;
`endif

    modport master (
`ifdef GHOST_MODE_OVERRIDE_EN
        output dbg_force_en,
        output dbg_force_mode,
`endif
        output frame_tick,
        output level_start,
        output pellet_eaten,
        output pause,
        input  game_mode,
        input  mode_changed,
        input  fright_flash,
        input  phase_idx
    );

    modport slave (
`ifdef GHOST_MODE_OVERRIDE_EN
        input  dbg_force_en,
        input  dbg_force_mode,
`endif
        input  frame_tick,
        input  level_start,
        input  pellet_eaten,
        input  pause,
        output game_mode,
        output mode_changed,
        output fright_flash,
        output phase_idx
    );
endinterface

// File: rtl/tick_down_counter.sv
// Loadable down-counter that saturates at zero; is_one_o marks the last tick of an interval.
module tick_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] value_o,
    output logic         is_one_o
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i)
            count_d = load_val_i;
        else if (en_i && (count_q != '0))
            count_d = count_q - W'(1);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign value_o  = count_q;
    assign is_one_o = (count_q == W'(1));
endmodule

// File: rtl/ghost_mode_scheduler.sv
// Global ghost mode scheduler: timed scatter/chase table with frightened pre-emption.
// Defining GHOST_MODE_OVERRIDE_EN adds a debug force of game_mode that freezes all timers.
module ghost_mode_scheduler
    import ghost_mode_pkg::*;
#(
    parameter int TICKS_PER_SEC = 60,
    parameter int FRIGHT_SEC    = 6,
    parameter int FLASH_TICKS   = 120
) (
    input logic                   clk,
    input logic                   resetN,
    ghost_mode_scheduler_if.slave bus
);
    localparam int            CW          = cnt_width(TICKS_PER_SEC, FRIGHT_SEC);
    localparam logic [CW-1:0] FRIGHT_LOAD = CW'(FRIGHT_SEC * TICKS_PER_SEC);
    localparam logic [CW-1:0] FLASH_LIMIT = CW'(FLASH_TICKS);

    function automatic logic [CW-1:0] phase_load(logic [2:0] idx);
        return CW'(phase_sec(idx) * TICKS_PER_SEC);
    endfunction

    sched_state_e  state_q, state_d;
    logic [2:0]    phase_q, phase_d;
    logic [1:0]    mode_q, mode_d;
    logic          mc_q, mc_d;
    logic          flash_q, flash_d;

    logic          freeze, tick, force_edge;
    logic          ph_load, ph_en, ph_is_one;
    logic [CW-1:0] ph_load_val, ph_val;
    logic          fr_load, fr_en, fr_is_one;
    logic [CW-1:0] fr_load_val, fr_val, fr_nxt;

    assign tick = bus.frame_tick && !freeze;

    tick_down_counter #(.W(CW)) u_phase_cnt (
        .clk        (clk),
        .resetN     (resetN),
        .load_i     (ph_load),
        .load_val_i (ph_load_val),
        .en_i       (ph_en),
        .value_o    (ph_val),
        .is_one_o   (ph_is_one)
    );

    tick_down_counter #(.W(CW)) u_fright_cnt (
        .clk        (clk),
        .resetN     (resetN),
        .load_i     (fr_load),
        .load_val_i (fr_load_val),
        .en_i       (fr_en),
        .value_o    (fr_val),
        .is_one_o   (fr_is_one)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        mode_d      = mode_q;
        mc_d        = 1'b0;
        ph_load     = 1'b0;
        ph_load_val = '0;
        ph_en       = 1'b0;
        fr_load     = 1'b0;
        fr_load_val = FRIGHT_LOAD;
        fr_en       = 1'b0;

        unique case (state_q)
            IDLE: ;
            SCHED: begin
                // A zero phase counter means the endless last phase.
                ph_en = tick && (ph_val != '0);
                if (ph_en && ph_is_one) begin
                    phase_d     = phase_q + 3'd1;
                    ph_load     = 1'b1;
                    ph_load_val = phase_load(phase_q + 3'd1);
                    mode_d      = phase_mode(phase_q + 3'd1);
                    mc_d        = 1'b1;
                end
                if (bus.pellet_eaten) begin
                    state_d = FRIGHT;
                    mode_d  = FRIGHTENED_MODE;
                    mc_d    = 1'b1;
                    fr_load = 1'b1;
                end
            end
            FRIGHT: begin
                if (bus.pellet_eaten) begin
                    fr_load = 1'b1;
                end else if (tick) begin
                    fr_en = 1'b1;
                    if (fr_is_one) begin
                        state_d = SCHED;
                        mode_d  = phase_mode(phase_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.level_start) begin
            state_d     = SCHED;
            phase_d     = 3'd0;
            mode_d      = SCATTER_MODE;
            mc_d        = 1'b0;
            ph_load     = 1'b1;
            ph_load_val = phase_load(3'd0);
            fr_load     = 1'b1;
            fr_load_val = '0;
        end

        // Next fright count, so the flash flag can be registered in step with the counter.
        fr_nxt = fr_val;
        if (fr_load)
            fr_nxt = fr_load_val;
        else if (fr_en && (fr_val != '0))
            fr_nxt = fr_val - CW'(1);
        flash_d = (state_d == FRIGHT) && (fr_nxt != '0) && (fr_nxt <= FLASH_LIMIT);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            phase_q <= 3'd0;
            mode_q  <= SCATTER_MODE;
            mc_q    <= 1'b0;
            flash_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            mc_q    <= mc_d || force_edge;
            flash_q <= flash_d;
        end
    end

`ifdef GHOST_MODE_OVERRIDE_EN
    logic       force_q;
    logic [1:0] out_mode_q;

    assign freeze     = bus.pause || bus.dbg_force_en;
    assign force_edge = bus.dbg_force_en ^ force_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            force_q    <= 1'b0;
            out_mode_q <= SCATTER_MODE;
        end else begin
            force_q    <= bus.dbg_force_en;
            out_mode_q <= bus.dbg_force_en ? bus.dbg_force_mode : mode_d;
        end
    end

    assign bus.game_mode = out_mode_q;
`else
    assign freeze        = bus.pause;
    assign force_edge    = 1'b0;
    assign bus.game_mode = mode_q;
`endif

    assign bus.phase_idx    = phase_q;
    assign bus.mode_changed = mc_q;
    assign bus.fright_flash = flash_q;
endmodule
